// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32-subset datapath.
// The state register is clocked; the datapath controls are decoded
// combinationally from the current state, so the FETCH/EXEC/MEM handshakes
// can respond to mem_ready and zero in the same cycle (Mealy).
// Optional feature: define HALT_ON_ILLEGAL_EN to park the FSM in TRAP on an
// illegal opcode instead of skipping back to FETCH.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_data,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] mem_to_reg,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I      = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;

    state_t state_reg;

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui;
    logic is_legal, is_alu_wb, branch_taken;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);
    assign is_alu_wb = is_r | is_i | is_lui;
    assign is_legal  = is_alu_wb | is_load | is_store | is_branch | is_jal;

    // beq takes on zero, bne on !zero; other branch kinds never redirect
    assign branch_taken = (funct3 == 3'd0) ? zero :
                          (funct3 == 3'd1) ? ~zero : 1'b0;

    assign state = state_reg;

    // State transitions; rst overrides everything, abandoning any memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_legal) begin
                        state_reg <= S_EXEC;
                    end else begin
`ifdef HALT_ON_ILLEGAL_EN
                        state_reg <= S_TRAP;
`else
                        state_reg <= S_FETCH;
`endif
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) state_reg <= S_MEM;
                    else if (is_alu_wb)      state_reg <= S_WB;
                    else                     state_reg <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) state_reg <= is_load ? S_WB : S_FETCH;
                end
                S_WB: state_reg <= S_FETCH;
                S_TRAP: begin
`ifdef HALT_ON_ILLEGAL_EN
                    state_reg <= S_TRAP;
`else
                    state_reg <= S_FETCH;
`endif
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the current state plus handshake inputs
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 2'd0;
        pc_src       = 2'd0;
        mem_to_reg   = 2'd0;
        retire       = 1'b0;
        illegal      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                // PC + 4 computed in the ALU while the instruction is read
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUOut as a speculative branch/jump target
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                illegal   = ~is_legal;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_src_a = 2'd1;
                    alu_op    = 2'd2;
                end else if (is_i) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    alu_op    = 2'd2;
                end else if (is_lui) begin
                    alu_src_a = 2'd3;
                    alu_src_b = 2'd2;
                end else if (is_load || is_store) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                end else if (is_branch) begin
                    alu_src_a = 2'd1;
                    alu_op    = 2'd1;
                    pc_src    = 2'd1;
                    pc_write  = branch_taken;
                    retire    = 1'b1;
                end else if (is_jal) begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_src     = 2'd1;
                    retire     = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = is_store;
                retire       = is_store & mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load ? 2'd1 : 2'd0;
                retire     = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port opcode, input, 7 bits: instruction register bits [6:0].
REQ-004 The block SHALL have port funct3, input, 3 bits: instruction register bits [14:12].
REQ-005 The block SHALL have port zero, input, 1 bit: ALU result-equals-zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: shared memory completed the current access this cycle.
REQ-007 The block SHALL have ports mem_req, mem_we and mem_sel_data, outputs, 1 bit each: memory access request, write enable, and address select (0 = PC, 1 = ALUOut).
REQ-008 The block SHALL have ports pc_write, ir_write and reg_write, outputs, 1 bit each: register update enables.
REQ-009 The block SHALL have ports alu_src_a, alu_src_b, alu_op, pc_src and mem_to_reg, outputs, 2 bits each, with the following encodings.
- alu_src_a: 0 = PC, 1 = rs1, 2 = oldPC, 3 = zero.
- alu_src_b: 0 = rs2, 1 = const 4, 2 = imm.
- alu_op: 0 = add, 1 = sub, 2 = funct-decoded.
- pc_src: 0 = ALU result, 1 = ALUOut.
- mem_to_reg: 0 = ALUOut, 1 = memory data, 2 = PC.
REQ-010 The block SHALL have port state, output, 3 bits: current FSM state.
REQ-011 The block SHALL have ports retire and illegal, outputs, 1 bit each: one-cycle pulses.

Function
REQ-012 The FSM SHALL have states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. TRAP SHALL be reachable only under REQ-027.
REQ-013 Every output not asserted by a rule below SHALL be 0.
REQ-014 In FETCH, the block SHALL assert mem_req = 1 with mem_sel_data = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0 and pc_src = 0, and SHALL hold FETCH while mem_ready = 0.
REQ-015 In FETCH with mem_ready = 1, the block SHALL assert ir_write = 1 and pc_write = 1 in the same cycle (Mealy) and move to DECODE.
REQ-016 DECODE SHALL last exactly 1 cycle with alu_src_a = 2, alu_src_b = 2 and alu_op = 0 (branch/jump target into ALUOut).
REQ-017 DECODE SHALL take the next state from opcode as follows.
- 51 (R), 19 (I-ALU), 3 (LOAD), 35 (STORE), 99 (BRANCH), 111 (JAL), 55 (LUI): go to EXEC.
- Any other opcode: illegal = 1 for one cycle, then go to FETCH (no state change elsewhere).
REQ-018 EXEC SHALL drive the datapath per opcode as follows.
- R: alu_src_a = 1, alu_src_b = 0, alu_op = 2, then WB.
- I-ALU: alu_src_a = 1, alu_src_b = 2, alu_op = 2, then WB.
- LUI: alu_src_a = 3, alu_src_b = 2, alu_op = 0, then WB.
- LOAD/STORE: alu_src_a = 1, alu_src_b = 2, alu_op = 0, then MEM.
REQ-019 EXEC for BRANCH SHALL use alu_src_a = 1, alu_src_b = 0, alu_op = 1 and pc_src = 1.
- Set pc_write = (funct3 == 0 ? zero : funct3 == 1 ? !zero : 0).
- Then go to FETCH with retire = 1.
REQ-020 EXEC for JAL SHALL assert reg_write = 1, mem_to_reg = 2, pc_write = 1 and pc_src = 1, then go to FETCH with retire = 1.
REQ-021 In MEM, the block SHALL assert mem_req = 1, mem_sel_data = 1 and mem_we = (opcode == 35), and SHALL hold MEM while mem_ready = 0.
REQ-022 In MEM with mem_ready = 1, LOAD SHALL go to WB, and STORE SHALL go to FETCH with retire = 1.
REQ-023 WB SHALL assert reg_write = 1 with mem_to_reg = (opcode == 3 ? 1 : 0), and retire = 1, then go to FETCH.
REQ-024 Each instruction SHALL produce reg_write for at most 1 cycle, and the block SHALL never assert mem_we outside MEM.
REQ-025 Cycle counts with mem_ready tied to 1 SHALL be as follows.
- R, I-ALU, LUI: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- BRANCH, JAL: 3 cycles.

Reset
REQ-026 On a rising clk edge with rst = 1, the block SHALL set state to FETCH.
- All registered pulses SHALL clear.
- The cycle after reset SHALL present FETCH outputs (mem_req = 1).
- rst during a MEM or FETCH wait SHALL abandon the access, with mem_we = 0 from that edge.
- rst SHALL take priority over every transition.

Configuration
REQ-027 With HALT_ON_ILLEGAL_EN defined, an illegal opcode in DECODE SHALL go to TRAP.
- TRAP asserts illegal = 1 continuously and holds all other outputs at 0.
- TRAP is left only by rst.
- Without HALT_ON_ILLEGAL_EN, REQ-017 applies and state value 5 SHALL be unreachable.

Verification
REQ-028 addi x1, x0, 5 (opcode 19) with mem_ready = 1 -> state sequence 0, 1, 2, 4, 0; reg_write high 1 cycle in WB; retire pulse at the WB cycle.
REQ-029 beq (opcode 99, funct3 0), zero = 1 in EXEC -> pc_write = 1, pc_src = 1, 3 cycles total; same with zero = 0 -> pc_write = 0 in EXEC.
REQ-030 lw (opcode 3) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, mem_req = 1 and mem_we = 0 throughout, then WB with mem_to_reg = 1.
REQ-031 sw (opcode 35) with rst asserted during the MEM wait -> next state FETCH, mem_we = 0 after the edge, no retire.
REQ-032 opcode 0x7F -> illegal pulse 1 cycle then FETCH; with HALT_ON_ILLEGAL_EN -> state = 5 sticky for 20 cycles with all enables 0 until rst.
REQ-033 jal (opcode 111) -> EXEC with reg_write = 1, mem_to_reg = 2, pc_write = 1, pc_src = 1; next state FETCH.
